// File: rtl/stats_dump.sv
// stats_dump: walks a range of statistics addresses, holding each address on
// o_stat_addr for SETTLE+1 cycles before capturing i_stats. Each captured word
// is presented on a valid/ready output with its address and a last-word flag.
//
// Ports:
//   i_clk          sole clock, rising edge
//   i_rst          synchronous active-high reset
//   i_start        one-cycle request to dump [i_first_addr .. i_last_addr]
//   i_abort        terminate the dump in progress
//   i_first_addr   first statistics address of the range
//   i_last_addr    last statistics address of the range (range wraps mod 256)
//   o_stat_addr    address driven to the statistics unit
//   i_stats        statistics word for o_stat_addr (one-cycle registered path)
//   o_out_data     captured statistics word
//   o_out_addr     address of o_out_data
//   o_out_last     marks the final word of the range
//   o_out_valid    output word valid
//   i_out_ready    sink accepts the word
//   o_busy         dump in progress
//   o_done         one-cycle pulse on normal completion
module stats_dump #(
  parameter int unsigned SETTLE = 1  // legal range 1..3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [7:0]  i_first_addr,
  input  logic [7:0]  i_last_addr,
  output logic [7:0]  o_stat_addr,
  input  logic [31:0] i_stats,
  output logic [31:0] o_out_data,
  output logic [7:0]  o_out_addr,
  output logic        o_out_last,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSet  = 2'd1,
    StHold = 2'd2
  } state_e;

  localparam logic [1:0] SettleLast = 2'(SETTLE);

  state_e      r_state;
  logic [1:0]  r_cnt;
  logic [7:0]  r_last_addr;
  logic [7:0]  r_stat_addr;
  logic [31:0] r_out_data;
  logic [7:0]  r_out_addr;
  logic        r_out_last;
  logic        r_out_valid;
  logic        r_busy;
  logic        r_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= 2'd0;
      r_last_addr <= 8'd0;
      r_stat_addr <= 8'd0;
      r_out_data  <= 32'd0;
      r_out_addr  <= 8'd0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // START together with ABORT is a no-op.
          if (i_start && !i_abort) begin
            r_last_addr <= i_last_addr;
            r_stat_addr <= i_first_addr;
            r_cnt       <= 2'd0;
            r_busy      <= 1'b1;
            r_state     <= StSet;
          end
        end
        StSet: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else if (r_cnt == SettleLast) begin
            // Address has been stable long enough for the registered stats path.
            r_out_data  <= i_stats;
            r_out_addr  <= r_stat_addr;
            r_out_last  <= (r_stat_addr == r_last_addr);
            r_out_valid <= 1'b1;
            r_state     <= StHold;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        StHold: begin
          // A handshake still counts when ABORT arrives in the same cycle.
          if (i_out_ready && !r_out_last) begin
            r_stat_addr <= r_stat_addr + 8'd1;
          end
          if (i_abort) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StIdle;
            end else begin
              r_cnt   <= 2'd0;
              r_state <= StSet;
            end
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign o_stat_addr = r_stat_addr;
  assign o_out_data  = r_out_data;
  assign o_out_addr  = r_out_addr;
  assign o_out_last  = r_out_last;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule
